// File: rtl/traffic_sensor_conditioner.sv
// Conditions two bouncing car detectors into traffic requests for a light controller:
// sync + debounce, falling-edge hold stretch, per-street starvation guard, sticky lamp fault.
module traffic_sensor_conditioner #(
  parameter int DEBOUNCE  = 4,
  parameter int HOLD      = 3,
  parameter int MAX_GREEN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_a,
  input  logic       raw_b,
  input  logic [1:0] la,
  input  logic [1:0] lb,
  output logic       ta,
  output logic       tb,
  output logic       deb_a,
  output logic       deb_b,
  output logic       force_a,
  output logic       force_b,
  output logic       err
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam int CW = $clog2(MAX_GREEN + 1);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [DW-1:0] DB_ONE  = DW'(1);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_GREEN);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_FORCE = 2'd2;

  localparam logic [1:0] LAMP_GREEN = 2'b10;
  localparam logic [1:0] LAMP_BAD   = 2'b11;

  logic [1:0]      raw;
  logic [1:0][1:0] lamp;
  logic [1:0]      deb;
  logic [1:0]      oth_deb;
  logic [1:0]      t_q;
  logic [1:0]      frc_q;
  logic            err_q;
  logic            err_nx;

  assign raw     = {raw_b, raw_a};
  assign lamp    = {lb, la};
  assign oth_deb = {deb[0], deb[1]};

  // Fault is folded in combinationally so a guard can never enter FORCE on the edge err sets.
  assign err_nx = err_q | (la == LAMP_BAD) | (lb == LAMP_BAD) |
                  ((la == LAMP_GREEN) & (lb == LAMP_GREEN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_nx;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic          s1;
    logic          s2;
    logic          deb_r;
    logic [DW-1:0] dcnt;
    logic          deb_chg;
    logic [HW-1:0] hold;
    logic          req;
    logic          cond;
    logic [1:0]    st;
    logic [1:0]    st_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          t_r;
    logic          f_r;

    assign deb_chg = (s2 != deb_r) && (dcnt == DB_LAST);
    assign req     = deb_r | (hold != '0);
    assign cond    = (lamp[i] == LAMP_GREEN) & req & oth_deb[i];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        deb_r <= 1'b0;
        dcnt  <= '0;
        hold  <= '0;
      end else begin
        s1 <= raw[i];
        s2 <= s1;
        if (s2 == deb_r) begin
          dcnt <= '0;
        end else if (deb_chg) begin
          deb_r <= s2;
          dcnt  <= '0;
        end else begin
          dcnt <= dcnt + DB_ONE;
        end
        // A new rising level cancels any stretch still running from the previous fall.
        if (deb_chg && s2) begin
          hold <= '0;
        end else if (deb_chg) begin
          hold <= HOLD_LD;
        end else if (hold != '0) begin
          hold <= hold - HOLD_ONE;
        end
      end
    end

    always_comb begin
      st_nx  = st;
      cnt_nx = cnt;
      if (err_nx) begin
        st_nx  = ST_IDLE;
        cnt_nx = '0;
      end else begin
        case (st)
          ST_IDLE: begin
            if (cond) begin
              st_nx  = ST_COUNT;
              cnt_nx = CNT_ONE;
            end
          end
          ST_COUNT: begin
            if (!cond) begin
              st_nx  = ST_IDLE;
              cnt_nx = '0;
            end else if (cnt == CNT_MAX) begin
              st_nx = ST_FORCE;
            end else begin
              cnt_nx = cnt + CNT_ONE;
            end
          end
          ST_FORCE: begin
            if (lamp[i] != LAMP_GREEN) begin
              st_nx  = ST_IDLE;
              cnt_nx = '0;
            end
          end
          default: begin
            st_nx  = ST_IDLE;
            cnt_nx = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        st  <= ST_IDLE;
        cnt <= '0;
        t_r <= 1'b0;
        f_r <= 1'b0;
      end else begin
        st  <= st_nx;
        cnt <= cnt_nx;
        t_r <= req & (st_nx != ST_FORCE);
        f_r <= (st_nx == ST_FORCE);
      end
    end

    assign deb[i]   = deb_r;
    assign t_q[i]   = t_r;
    assign frc_q[i] = f_r;
  end

  assign ta      = t_q[0];
  assign tb      = t_q[1];
  assign deb_a   = deb[0];
  assign deb_b   = deb[1];
  assign force_a = frc_q[0];
  assign force_b = frc_q[1];
  assign err     = err_q;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Bench for traffic_sensor_conditioner: directed timing scenarios plus a random run against a rule-level model.
module tb_traffic_sensor_conditioner;

  localparam int DEBOUNCE  = 4;
  localparam int HOLD      = 3;
  localparam int MAX_GREEN = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       raw_a = 1'b0;
  logic       raw_b = 1'b0;
  logic [1:0] la = 2'b00;
  logic [1:0] lb = 2'b00;
  logic       ta, tb, deb_a, deb_b, force_a, force_b, err;
  logic [6:0] obs;
  logic [6:0] exp_v;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_sensor_conditioner #(
    .DEBOUNCE (DEBOUNCE),
    .HOLD     (HOLD),
    .MAX_GREEN(MAX_GREEN)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .raw_a  (raw_a),
    .raw_b  (raw_b),
    .la     (la),
    .lb     (lb),
    .ta     (ta),
    .tb     (tb),
    .deb_a  (deb_a),
    .deb_b  (deb_b),
    .force_a(force_a),
    .force_b(force_b),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Output vector order: {ta, tb, deb_a, deb_b, force_a, force_b, err}
  assign obs = {ta, tb, deb_a, deb_b, force_a, force_b, err};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    raw_a = 1'b0;
    raw_b = 1'b0;
    la    = 2'b00;
    lb    = 2'b00;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    n_checks++;
    if (obs !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_held: outputs %b, required %b", obs, 7'b0);
    end
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++;
      if (obs !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_idle edge %0d: outputs %b, required %b", k, obs, 7'b0);
      end
    end
  endtask

  task automatic test_debounce_rise();
    do_reset();
    raw_a = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp_v = {k >= 7, 1'b0, k >= 6, 1'b0, 1'b0, 1'b0, 1'b0};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL debounce_rise edge %0d: outputs %b, required %b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    raw_a = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 3) raw_a = 1'b0;
      n_checks++;
      if (obs !== 7'b0) begin
        n_fail++;
        $display("FAIL glitch edge %0d: outputs %b, required %b", k, obs, 7'b0);
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    raw_a = 1'b1;
    for (int k = 1; k <= 8; k++) step();
    raw_a = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_v = {k <= 9, 1'b0, k < 6, 1'b0, 1'b0, 1'b0, 1'b0};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL hold_stretch edge %0d: outputs %b, required %b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_starvation();
    logic fa;
    do_reset();
    raw_a = 1'b1;
    raw_b = 1'b1;
    la    = 2'b10;
    for (int k = 1; k <= 23; k++) begin
      step();
      if (k == 20) la = 2'b01;
      // Contention starts after edge 6, COUNT entered at edge 7, FORCE from edge 15 while green.
      fa = (k >= 15) && (k <= 20);
      exp_v = {(k >= 7) && !fa, k >= 7, k >= 6, k >= 6, fa, 1'b0, 1'b0};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL starvation edge %0d: outputs %b, required %b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_err();
    do_reset();
    step();
    la = 2'b10;
    lb = 2'b10;
    step();
    la = 2'b00;
    lb = 2'b00;
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: err %b, required 1", err);
    end
    raw_a = 1'b1;
    raw_b = 1'b1;
    la    = 2'b10;
    for (int k = 1; k <= 25; k++) begin
      step();
      exp_v = {k >= 7, k >= 7, k >= 6, k >= 6, 1'b0, 1'b0, 1'b1};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL err_no_force edge %0d: outputs %b, required %b", k, obs, exp_v);
      end
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== 7'b0) begin
      n_fail++;
      $display("FAIL err_reset: outputs %b, required %b", obs, 7'b0);
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_force();
    do_reset();
    raw_a = 1'b1;
    raw_b = 1'b1;
    la    = 2'b10;
    for (int k = 1; k <= 16; k++) step();
    n_checks++;
    if (force_a !== 1'b1) begin
      n_fail++;
      $display("FAIL midforce_setup: force_a %b, required 1", force_a);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== 7'b0) begin
      n_fail++;
      $display("FAIL midforce_async_clear: outputs %b, required %b", obs, 7'b0);
    end
    step();
    reset = 1'b0;
    la    = 2'b00;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp_v = {k >= 7, k >= 7, k >= 6, k >= 6, 1'b0, 1'b0, 1'b0};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL midforce_resume edge %0d: outputs %b, required %b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_random();
    bit s1[2], s2[2], deb[2], frc[2], t[2], m_err;
    int run[2], hold[2], grn[2];
    bit n_deb[2], n_frc[2], n_t[2], n_err, req, cont;
    int n_run[2], n_hold[2], n_grn[2];
    bit rv[2];
    int own[2];
    int lamp_left;
    int sel;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      s1[c] = 0; s2[c] = 0; deb[c] = 0; frc[c] = 0; t[c] = 0;
      run[c] = 0; hold[c] = 0; grn[c] = 0;
    end
    m_err     = 0;
    lamp_left = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (raw_a ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 5) == 0)) raw_a = ~raw_a;
      if (raw_b ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 5) == 0)) raw_b = ~raw_b;
      if (lamp_left == 0) begin
        lamp_left = $urandom_range(1, 24);
        if (cyc < 2500) begin
          sel = $urandom_range(0, 5);
          case (sel)
            0: begin la = 2'b10; lb = 2'b00; end
            1: begin la = 2'b00; lb = 2'b10; end
            2: begin la = 2'b01; lb = 2'b00; end
            3: begin la = 2'b00; lb = 2'b01; end
            4: begin la = 2'b10; lb = 2'b01; end
            default: begin la = 2'b00; lb = 2'b00; end
          endcase
        end else begin
          la = 2'($urandom_range(0, 3));
          lb = 2'($urandom_range(0, 3));
        end
      end
      lamp_left--;
      step();

      rv[0]  = raw_a;
      rv[1]  = raw_b;
      own[0] = int'(la);
      own[1] = int'(lb);
      n_err  = m_err || (own[0] == 3) || (own[1] == 3) || (own[0] == 2 && own[1] == 2);
      for (int c = 0; c < 2; c++) begin
        req  = deb[c] || (hold[c] > 0);
        cont = (own[c] == 2) && req && deb[1 - c];
        if (n_err) begin
          n_frc[c] = 0;
          n_grn[c] = 0;
        end else if (frc[c]) begin
          n_frc[c] = (own[c] == 2);
          n_grn[c] = 0;
        end else if (cont) begin
          n_grn[c] = grn[c] + 1;
          n_frc[c] = (n_grn[c] > MAX_GREEN);
        end else begin
          n_grn[c] = 0;
          n_frc[c] = 0;
        end
        n_t[c] = req && !n_frc[c];
        n_deb[c]  = deb[c];
        n_hold[c] = (hold[c] > 0) ? hold[c] - 1 : 0;
        n_run[c]  = 0;
        if (s2[c] != deb[c]) begin
          n_run[c] = run[c] + 1;
          if (n_run[c] == DEBOUNCE) begin
            n_deb[c]  = s2[c];
            n_run[c]  = 0;
            n_hold[c] = s2[c] ? 0 : HOLD;
          end
        end
      end
      for (int c = 0; c < 2; c++) begin
        s2[c] = s1[c]; s1[c] = rv[c];
        deb[c] = n_deb[c]; run[c] = n_run[c]; hold[c] = n_hold[c];
        grn[c] = n_grn[c]; frc[c] = n_frc[c]; t[c] = n_t[c];
      end
      m_err = n_err;

      exp_v = {t[0], t[1], deb[0], deb[1], frc[0], frc[1], m_err};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL random cycle %0d: outputs %b, required %b", cyc, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce_rise();
    test_glitch();
    test_hold();
    test_starvation();
    test_err();
    test_reset_mid_force();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
